// File: rtl/ssd_scan_ctrl.sv
// 4-digit multiplexed seven-segment scanner for the stopwatch display.
// Frame snapshots, guard blanking, leading-zero blank, colon and pause blink.
module ssd_scan_ctrl #(
  parameter int SCAN_CNT_MAX = 25000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] min1,
  input  logic [3:0] min2,
  input  logic [3:0] sec1,
  input  logic [3:0] sec2,
  input  logic       blink,
  input  logic       blank_lz,
  output logic [3:0] ssd_ctl,
  output logic [7:0] segs,
  output logic       frame_tick
);

  localparam int DW = (SCAN_CNT_MAX > 1) ? $clog2(SCAN_CNT_MAX) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DW-1:0] r_div;
  logic [1:0]    r_idx;
  logic [15:0]   r_snap;
  logic          r_phase;
  logic [BW-1:0] r_bcnt;
  logic [3:0]    r_ctl;
  logic [7:0]    r_segs;
  logic          r_tick;

  logic          w_slot_end;
  logic          w_wrap;
  logic          w_last_frame;
  logic [3:0]    w_digit;
  logic [3:0]    w_sel;
  logic [6:0]    w_pat;
  logic          w_on;

  assign w_slot_end   = (r_div == DW'(SCAN_CNT_MAX - 1));
  assign w_wrap       = w_slot_end && (r_idx == 2'd3);
  assign w_last_frame = (r_bcnt == BW'(BLINK_FRAMES - 1));

  always_comb begin
    w_digit = r_snap[3:0];
    w_sel   = 4'b1110;
    unique case (r_idx)
      2'd0: begin w_digit = r_snap[3:0];   w_sel = 4'b1110; end
      2'd1: begin w_digit = r_snap[7:4];   w_sel = 4'b1101; end
      2'd2: begin w_digit = r_snap[11:8];  w_sel = 4'b1011; end
      2'd3: begin w_digit = r_snap[15:12]; w_sel = 4'b0111; end
    endcase
  end

  // abcdefg, active-low; non-BCD codes show a dash
  always_comb begin
    w_pat = 7'b1111110;
    case (w_digit)
      4'd0: w_pat = 7'b0000001;
      4'd1: w_pat = 7'b1001111;
      4'd2: w_pat = 7'b0010010;
      4'd3: w_pat = 7'b0000110;
      4'd4: w_pat = 7'b1001100;
      4'd5: w_pat = 7'b0100100;
      4'd6: w_pat = 7'b0100000;
      4'd7: w_pat = 7'b0001111;
      4'd8: w_pat = 7'b0000000;
      4'd9: w_pat = 7'b0000100;
      default: w_pat = 7'b1111110;
    endcase
  end

  assign w_on = (r_div >= DW'(GUARD))
             && !(blank_lz && (r_idx == 2'd3) && (r_snap[15:12] == 4'd0))
             && !(blink && r_phase);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= '0;
      r_idx   <= '0;
      r_snap  <= '0;
      r_phase <= 1'b0;
      r_bcnt  <= '0;
      r_ctl   <= 4'hF;
      r_segs  <= 8'hFF;
      r_tick  <= 1'b0;
    end else begin
      r_div  <= w_slot_end ? '0 : r_div + 1'b1;
      if (w_slot_end) r_idx <= r_idx + 2'd1;
      if (w_wrap) r_snap <= {min1, min2, sec1, sec2};
      r_tick <= w_wrap;
      if (!blink) begin
        r_bcnt  <= '0;
        r_phase <= 1'b0;
      end else if (w_wrap) begin
        r_bcnt <= w_last_frame ? '0 : r_bcnt + 1'b1;
        if (w_last_frame) r_phase <= ~r_phase;
      end
      r_ctl  <= w_on ? w_sel : 4'hF;
      r_segs <= {w_pat, (r_idx != 2'd2)};
    end
  end

  assign ssd_ctl    = r_ctl;
  assign segs       = r_segs;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: directed test-plan steps plus random traffic,
// checked every cycle against a frame/slot arithmetic reference model.
module tb_ssd_scan_ctrl;

  localparam int S  = 4;
  localparam int G  = 1;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] min1, min2, sec1, sec2;
  logic       blink, blank_lz;
  logic [3:0] ssd_ctl;
  logic [7:0] segs;
  logic       frame_tick;

  int nrun = 0;
  int nfail = 0;

  int          k;
  logic [15:0] msnap;
  int          nb;
  logic [6:0]  dec [16];

  always #5 clk = ~clk;

  ssd_scan_ctrl #(
    .SCAN_CNT_MAX(S),
    .GUARD(G),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .min1(min1),
    .min2(min2),
    .sec1(sec1),
    .sec2(sec2),
    .blink(blink),
    .blank_lz(blank_lz),
    .ssd_ctl(ssd_ctl),
    .segs(segs),
    .frame_tick(frame_tick)
  );

  task automatic step(input string tag);
    int         dv, ix;
    logic [3:0] d, ec;
    logic [7:0] es;
    logic       et, on, wrap;
    logic [15:0] sh;
    dv   = k % S;
    ix   = (k / S) % 4;
    sh   = msnap >> (4 * ix);
    d    = sh[3:0];
    on   = (dv >= G)
        && !(blank_lz && ix == 3 && msnap[15:12] == 4'd0)
        && !(blink && ((nb / BF) % 2 == 1));
    ec   = on ? ~(4'b0001 << ix) : 4'hF;
    es   = {dec[d], (ix != 2)};
    wrap = (k % (4 * S)) == (4 * S - 1);
    et   = wrap;
    @(posedge clk);
    if (rst) begin
      ec = 4'hF; es = 8'hFF; et = 1'b0;
      k = 0; msnap = '0; nb = 0;
    end else begin
      if (wrap) msnap = {min1, min2, sec1, sec2};
      if (!blink) nb = 0;
      else if (wrap) nb++;
      k++;
    end
    #1;
    nrun++;
    assert (ssd_ctl === ec) else begin
      nfail++;
      $error("FAIL %s ssd_ctl k=%0d got %b exp %b", tag, k, ssd_ctl, ec);
    end
    nrun++;
    assert (segs === es) else begin
      nfail++;
      $error("FAIL %s segs k=%0d got %b exp %b", tag, k, segs, es);
    end
    nrun++;
    assert (frame_tick === et) else begin
      nfail++;
      $error("FAIL %s frame_tick k=%0d got %b exp %b", tag, k, frame_tick, et);
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    dec[0] = 7'b0000001; dec[1] = 7'b1001111; dec[2] = 7'b0010010;
    dec[3] = 7'b0000110; dec[4] = 7'b1001100; dec[5] = 7'b0100100;
    dec[6] = 7'b0100000; dec[7] = 7'b0001111; dec[8] = 7'b0000000;
    dec[9] = 7'b0000100;
    for (int i = 10; i < 16; i++) dec[i] = 7'b1111110;
    k = 0; msnap = '0; nb = 0;

    rst = 1'b1; blink = 1'b0; blank_lz = 1'b0;
    min1 = 4'd1; min2 = 4'd2; sec1 = 4'd3; sec2 = 4'd4;
    run(2, "reset");
    rst = 1'b0;
    run(16, "frame0");
    run(24, "frame1");
    sec2 = 4'd5;
    run(24, "midframe");
    min1 = 4'd0; blank_lz = 1'b1;
    run(40, "lzblank");
    blank_lz = 1'b0;
    run(32, "lzshow");
    sec1 = 4'hC;
    run(32, "dash");
    sec1 = 4'd3; blink = 1'b1;
    run(150, "blink");
    while (!((nb / BF) % 2 == 1)) step("blinkwait");
    run(5, "dark");
    blink = 1'b0;
    run(40, "unblink");
    while ((k % (4 * S)) != 10) step("align");
    rst = 1'b1;
    step("midrst");
    rst = 1'b0;
    run(40, "restart");

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        min1 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
        min2 = 4'($urandom);
        sec1 = 4'($urandom);
        sec2 = 4'($urandom);
      end
      if ($urandom_range(0, 39) == 0) blink = ~blink;
      if ($urandom_range(0, 29) == 0) blank_lz = ~blank_lz;
      rst = ($urandom_range(0, 299) == 0);
      step("random");
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
